// File: rtl/wire_resolve_pkg.sv
// Shared definitions for the resolved-net pipeline.
// Provides the 2-bit four-state encoding constants and the net-kind enum
// used by wire_resolve_pipe and resolve_bit.
package wire_resolve_pkg;

  // Four-state bit encoding
  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  typedef enum logic [1:0] {
    WIRE   = 2'd0,
    WAND   = 2'd1,
    WOR    = 2'd2,
    TRIREG = 2'd3
  } mode_e;

endpackage

// File: rtl/wire_resolve_pipe_resolve_bit.sv
// resolve_bit: combinational resolution of one net bit across N drivers.
// Ports:
//   codes    - N 2-bit codes, driver i at codes[2*i +: 2]
//   en       - per-driver enable; a disabled driver counts as z
//   mode     - net kind (wire / wand / wor / trireg)
//   charge   - stored trireg charge for this bit
//   val      - resolved 2-bit code
//   conflict - 0 and 1 met with no x present (wire and trireg only)
module resolve_bit
  import wire_resolve_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [2*N-1:0] codes,
  input  logic [N-1:0]   en,
  input  logic [1:0]     mode,
  input  logic [1:0]     charge,
  output logic [1:0]     val,
  output logic           conflict
);

  logic any0, any1, anyx, allz;

  always_comb begin
    any0 = 1'b0;
    any1 = 1'b0;
    anyx = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (en[i]) begin
        unique case (codes[2*i +: 2])
          V0:      any0 = 1'b1;
          V1:      any1 = 1'b1;
          VX:      anyx = 1'b1;
          default: ;
        endcase
      end
    end
    allz = !(any0 || any1 || anyx);
  end

  always_comb begin
    val      = VZ;
    conflict = 1'b0;
    unique case (mode_e'(mode))
      WAND: begin
        if (any0)      val = V0;
        else if (anyx) val = VX;
        else if (any1) val = V1;
        else           val = VZ;
      end
      WOR: begin
        if (any1)      val = V1;
        else if (anyx) val = VX;
        else if (any0) val = V0;
        else           val = VZ;
      end
      default: begin
        // WIRE and TRIREG share resolution; trireg falls back to charge on z
        if (allz) begin
          val = (mode_e'(mode) == TRIREG) ? charge : VZ;
        end else if (anyx) begin
          val = VX;
        end else if (any0 && any1) begin
          val      = VX;
          conflict = 1'b1;
        end else if (any1) begin
          val = V1;
        end else begin
          val = V0;
        end
      end
    endcase
  end

endmodule

// File: rtl/wire_resolve_pipe.sv
// wire_resolve_pipe: registered four-state net resolver with valid/ready
// handshake, trireg charge storage and a saturating conflict counter.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input handshake for one driver set
//   drv_val, drv_en   - N drivers of W 2-bit codes each, per-driver enable
//   mode              - net kind, sampled with the transaction
//   out_valid/ready   - output handshake
//   out_val           - resolved net (W 2-bit codes)
//   out_conflict      - held result had at least one conflicting bit
//   conflict_cnt      - saturating count of accepted conflicting sets
module wire_resolve_pipe
  import wire_resolve_pkg::*;
#(
  parameter int unsigned W     = 5,
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*2*W-1:0]   drv_val,
  input  logic [N-1:0]       drv_en,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_val,
  output logic               out_conflict,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic [2*W-1:0]   res;
  logic [W-1:0]     bit_conf;
  logic             accept;

  logic             valid_q, valid_d;
  logic [2*W-1:0]   val_q, val_d;
  logic             conf_q, conf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   charge_q, charge_d;

  for (genvar b = 0; b < int'(W); b++) begin : g_bit
    logic [2*N-1:0] codes;

    // Gather bit b of every driver into one contiguous vector
    always_comb begin
      codes = '0;
      for (int d = 0; d < int'(N); d++) begin
        codes[2*d +: 2] = drv_val[(d*int'(W) + b)*2 +: 2];
      end
    end

    resolve_bit #(
      .N(N)
    ) u_resolve_bit (
      .codes    (codes),
      .en       (drv_en),
      .mode     (mode),
      .charge   (charge_q[2*b +: 2]),
      .val      (res[2*b +: 2]),
      .conflict (bit_conf[b])
    );
  end

  assign in_ready = !rst && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    val_d    = val_q;
    conf_d   = conf_q;
    cnt_d    = cnt_q;
    charge_d = charge_q;
    if (accept) begin
      valid_d = 1'b1;
      val_d   = res;
      conf_d  = |bit_conf;
      if (mode_e'(mode) == TRIREG) begin
        for (int b = 0; b < int'(W); b++) begin
          if (res[2*b +: 2] != VZ) charge_d[2*b +: 2] = res[2*b +: 2];
        end
      end
      if ((|bit_conf) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      val_q    <= {W{VX}};
      conf_q   <= 1'b0;
      cnt_q    <= '0;
      charge_q <= {W{VX}};
    end else begin
      valid_q  <= valid_d;
      val_q    <= val_d;
      conf_q   <= conf_d;
      cnt_q    <= cnt_d;
      charge_q <= charge_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_val      = val_q;
  assign out_conflict = conf_q;
  assign conflict_cnt = cnt_q;

endmodule
